// File: rtl/uart_rx_fifo_if.sv
// Receive-word handshake between the UART RX FIFO head and its consumer.
// Latency: none, plain wires; the producer drives show-ahead head data.
// Backpressure: consumer holds rx_ready_i low to keep the head word in place.
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data_o;
   logic                  parity_err_o;
   logic                  frame_err_o;
   logic                  rx_valid_o;
   logic                  rx_ready_i;

   // FIFO side: presents the head word, observes the pop request
   modport master (
      output rx_data_o,
      output parity_err_o,
      output frame_err_o,
      output rx_valid_o,
      input  rx_ready_i
   );

   // Consumer side (APB register file)
   modport slave (
      input  rx_data_o,
      input  parity_err_o,
      input  frame_err_o,
      input  rx_valid_o,
      output rx_ready_i
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (majority vote, parity/stop checks) feeding a show-ahead RX FIFO.
// Latency: word visible on rx_if the cycle after PUSH, i.e. two cycles after the last stop-bit decision.
// Backpressure: rx_valid_o/rx_ready_i pop; a word arriving at a full FIFO with no same-cycle pop is dropped and sets overrun_o.
// Build option: define UART_RX_BREAK_DETECT_EN to add break_o and suppress pushing of break frames.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        rx_i,
   input  logic                        rx_enable_i,
   input  logic [DIV_WIDTH-1:0]        cfg_div_i,
   input  logic [1:0]                  cfg_bits_i,
   input  logic                        cfg_parity_en_i,
   input  logic                        cfg_parity_odd_i,
   input  logic                        cfg_stop_bits_i,
   uart_rx_fifo_if.master              rx_if,
   output logic                        overrun_o,
   input  logic                        clear_overrun_i,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                        break_o,
`endif
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int EW = DATA_WIDTH + 2;

   // Sample points around mid-bit; the third one is also the decision point
   localparam logic [SW-1:0] L_SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] L_SAMP_B    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] L_SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] L_SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] L_FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_PUSH
`ifdef UART_RX_BREAK_DETECT_EN
      , S_BRK
`endif
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_rx_meta;
   logic                  r_rx_sync;
   logic                  r_rx_prev;
   logic                  w_start_edge;

   logic [DIV_WIDTH-1:0]  r_div;
   logic [DIV_WIDTH-1:0]  r_div_cnt;
   logic                  w_tick;
   logic [SW-1:0]         r_samp;
   logic                  r_smp_a;
   logic                  r_smp_b;
   logic                  w_decide;
   logic                  w_bit;

   logic [BW-1:0]         r_nbits;
   logic                  r_par_en;
   logic                  r_par_odd;
   logic                  r_stop2;

   logic [DATA_WIDTH-1:0] r_shift;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_par_acc;
   logic                  r_par_err;
   logic                  r_frm_err;
   logic                  r_stop_idx;
   logic                  w_push;

   logic [EW-1:0]         r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_valid;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_wr;
   logic [EW-1:0]         w_head;
   logic                  r_overrun;

`ifdef UART_RX_BREAK_DETECT_EN
   logic                  r_all_zero;
   logic                  w_brk_pulse;
   logic                  r_break;
`endif

   // Two-flop synchroniser plus one history flop for falling-edge detection; idle level is 1
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_start_edge = (r_state == S_IDLE) && rx_enable_i && r_rx_prev && !r_rx_sync;

   // Frame configuration is captured at the start edge so mid-frame changes are ignored
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_div     <= DIV_WIDTH'(1);
         r_nbits   <= BW'(DATA_WIDTH);
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_stop2   <= 1'b0;
      end else if (w_start_edge) begin
         r_div     <= (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
         r_nbits   <= BW'(DATA_WIDTH - 3) + BW'(cfg_bits_i);
         r_par_en  <= cfg_parity_en_i;
         r_par_odd <= cfg_parity_odd_i;
         r_stop2   <= cfg_stop_bits_i;
      end
   end

   assign w_tick = (r_state != S_IDLE) && (r_div_cnt == (r_div - DIV_WIDTH'(1)));

   // Oversample tick divider; held at zero in IDLE, so it restarts cleanly at every start edge
   always_ff @(posedge CLK) begin
      if (RST || (r_state == S_IDLE) || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
      end
   end

   // Per-bit tick counter; free-runs across bits so every bit is decided at the same phase
   always_ff @(posedge CLK) begin
      if (RST || w_start_edge) begin
         r_samp <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
      end else if (w_brk_pulse || ((r_state == S_BRK) && !r_rx_sync)) begin
         // in break-wait the counter measures consecutive idle ticks
         r_samp <= '0;
`endif
      end else if (w_tick) begin
         r_samp <= (r_samp == L_SAMP_LAST) ? '0 : r_samp + SW'(1);
      end
   end

   // Capture the first two of the three mid-bit samples
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_smp_a <= 1'b1;
         r_smp_b <= 1'b1;
      end else if (w_tick) begin
         if (r_samp == L_SAMP_A) r_smp_a <= r_rx_sync;
         if (r_samp == L_SAMP_B) r_smp_b <= r_rx_sync;
      end
   end

   assign w_decide = w_tick && (r_samp == L_SAMP_C);
   assign w_bit    = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_sync) | (r_smp_b & r_rx_sync);

   // Frame datapath: assemble data LSB first, accumulate parity, collect error flags
   always_ff @(posedge CLK) begin
      if (RST || w_start_edge) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_par_acc  <= 1'b0;
         r_par_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         r_stop_idx <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         r_all_zero <= 1'b1;
`endif
      end else if (w_decide) begin
         case (r_state)
            S_DATA: begin
               r_shift   <= r_shift | (DATA_WIDTH'(w_bit) << r_bit_cnt);
               r_bit_cnt <= r_bit_cnt + BW'(1);
               r_par_acc <= r_par_acc ^ w_bit;
`ifdef UART_RX_BREAK_DETECT_EN
               if (w_bit) r_all_zero <= 1'b0;
`endif
            end
            S_PARITY: begin
               // expected bit: XOR of data for even parity, XNOR for odd
               if (w_bit != (r_par_acc ^ r_par_odd)) r_par_err <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
               if (w_bit) r_all_zero <= 1'b0;
`endif
            end
            S_STOP: begin
               if (!w_bit) r_frm_err <= 1'b1;
               r_stop_idx <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and push strobe
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      w_brk_pulse = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_decide) w_state_nxt = w_bit ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_decide && (r_bit_cnt == (r_nbits - BW'(1)))) begin
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (w_decide) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_decide) begin
`ifdef UART_RX_BREAK_DETECT_EN
               if (!r_stop_idx && !w_bit && r_all_zero) begin
                  w_state_nxt = S_BRK;
                  w_brk_pulse = 1'b1;
               end else
`endif
               if (!r_stop_idx && r_stop2) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_state_nxt = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
         end
`ifdef UART_RX_BREAK_DETECT_EN
         S_BRK: begin
            // leave only after a full bit time of continuous idle line
            if (w_tick && r_rx_sync && (r_samp == L_SAMP_LAST)) w_state_nxt = S_IDLE;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // disabling the receiver abandons any frame in flight, including its push
      if (!rx_enable_i && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_push      = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         w_brk_pulse = 1'b0;
`endif
      end
   end

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == L_FULL);
   assign w_pop   = w_valid && rx_if.rx_ready_i;
   assign w_wr    = w_push && (!w_full || w_pop);

   // FIFO storage; entries are {frame_err, parity_err, data}
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= {r_frm_err, r_par_err, r_shift};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overrun; a new drop wins over a simultaneous clear
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_overrun <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overrun <= 1'b1;
      end else if (clear_overrun_i) begin
         r_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_BREAK_DETECT_EN
   // One-cycle break indication
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_break <= 1'b0;
      end else begin
         r_break <= w_brk_pulse;
      end
   end

   assign break_o = r_break;
`endif

   // Head word is gated with valid so an empty FIFO always presents zeros
   assign w_head             = r_mem[r_rd_ptr];
   assign rx_if.rx_valid_o   = w_valid;
   assign rx_if.rx_data_o    = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
   assign rx_if.parity_err_o = w_valid & w_head[DATA_WIDTH];
   assign rx_if.frame_err_o  = w_valid & w_head[DATA_WIDTH+1];
   assign overrun_o          = r_overrun;
   assign fifo_level_o       = r_count;

endmodule
